// File: rtl/fb_pixel_writer.sv
// fb_pixel_writer: launches one drawer pass, captures its pixels into a FIFO and writes them to the frame buffer.
// Latency: a pixel captured in cycle C is presented as mem_we/mem_addr/mem_data in cycle C+1 when the FIFO was empty.
// Backpressure: mem_ready=0 holds the head write; the drawer cannot stall, so a full FIFO drops pixels and sets overflow.
// Optional feature macro: PIXEL_CLIP_EN (drop pixels outside H_RES x V_RES).

// fb_pixel_fifo: generic synchronous FIFO; pointers carry one extra wrap bit to tell full from empty.
// Latency: a pushed entry is visible at the head on the next cycle.
// Backpressure: a push is refused only when full with no same-cycle pop.
module fb_pixel_fifo #(
  parameter int W     = 24,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push_i,
  input  logic [W-1:0] push_dat_i,
  input  logic         pop_i,
  output logic [W-1:0] head_dat_o,
  output logic         empty_o,
  output logic         full_o,
  output logic         push_ok_o
);
  localparam int PW = $clog2(DEPTH);

  logic [PW:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [W-1:0] mem_q [DEPTH];
  logic         do_pop;

  assign empty_o    = (wr_ptr_q == rd_ptr_q);
  assign full_o     = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign do_pop     = pop_i && !empty_o;
  // A pop frees the head slot in the same cycle, so a push at full is still taken.
  assign push_ok_o  = push_i && (!full_o || do_pop);
  assign head_dat_o = mem_q[rd_ptr_q[PW-1:0]];
  assign wr_ptr_d   = wr_ptr_q + {{PW{1'b0}}, push_ok_o};
  assign rd_ptr_d   = rd_ptr_q + {{PW{1'b0}}, do_pop};

  // Pointer update; wrap modulo DEPTH falls out of the index slice.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entry storage; contents are only meaningful between the pointers, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok_o) mem_q[wr_ptr_q[PW-1:0]] <= push_dat_i;
  end
endmodule

module fb_pixel_writer #(
  parameter int         H_RES       = 320,
  parameter int         V_RES       = 240,
  parameter int         ADDR_W      = 17,
  parameter int         FIFO_DEPTH  = 16,
  parameter logic [6:0] TRANSPARENT = 7'h7F
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic              done,
  output logic              draw_start,
  input  logic              draw_done,
  input  logic [8:0]        X_in,
  input  logic [7:0]        Y_in,
  input  logic [6:0]        color_in,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [6:0]        mem_data,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic              overflow
);
  localparam int ENT_W = ADDR_W + 7;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LAUNCH  = 3'd1;
  localparam logic [2:0] S_CAPTURE = 3'd2;
  localparam logic [2:0] S_DRAIN   = 3'd3;
  localparam logic [2:0] S_FINISH  = 3'd4;

  logic [2:0]        state_q, state_d;
  logic              overflow_q, overflow_d;
  logic              pix_vld, pix_keep, push, push_ok, pop;
  logic              fifo_empty, fifo_full;
  logic [ADDR_W-1:0] pix_addr;
  logic [ENT_W-1:0]  head_dat;

  // Every CAPTURE cycle without draw_done carries a pixel; the draw_done cycle's inputs are ignored.
  assign pix_vld  = (state_q == S_CAPTURE) && !draw_done;
  // Product formed at address width, so out-of-range coordinates alias rather than grow the bus.
  assign pix_addr = ADDR_W'(Y_in) * ADDR_W'(H_RES) + ADDR_W'(X_in);

`ifdef PIXEL_CLIP_EN
  logic pix_in_bounds;
  assign pix_in_bounds = (int'(X_in) < H_RES) && (int'(Y_in) < V_RES);
  assign pix_keep      = (color_in != TRANSPARENT) && pix_in_bounds;
`else
  assign pix_keep      = (color_in != TRANSPARENT);
`endif

  assign push = pix_vld && pix_keep;
  assign pop  = mem_we && mem_ready;

  fb_pixel_fifo #(
    .W     (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push_i     (push),
    .push_dat_i ({pix_addr, color_in}),
    .pop_i      (pop),
    .head_dat_o (head_dat),
    .empty_o    (fifo_empty),
    .full_o     (fifo_full),
    .push_ok_o  (push_ok)
  );

  // Head entry drives the write port; bus reads zero while idle.
  assign mem_we     = !fifo_empty;
  assign mem_addr   = mem_we ? head_dat[ENT_W-1:7] : '0;
  assign mem_data   = mem_we ? head_dat[6:0] : '0;
  assign draw_start = (state_q == S_LAUNCH);
  assign done       = (state_q == S_FINISH);
  assign overflow   = overflow_q;

  // Pass sequencing plus the sticky overflow flag (cleared when a new pass is accepted).
  always_comb begin
    state_d    = state_q;
    overflow_d = overflow_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_LAUNCH;
          overflow_d = 1'b0;
        end
      end
      S_LAUNCH:  state_d = S_CAPTURE;
      S_CAPTURE: if (draw_done) state_d = S_DRAIN;
      S_DRAIN:   if (fifo_empty) state_d = S_FINISH;
      S_FINISH:  state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    if (push && !push_ok) overflow_d = 1'b1;
  end

  // State and flag registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      overflow_q <= overflow_d;
    end
  end
endmodule

// File: tb/tb_fb_pixel_writer.sv
`timescale 1ns/1ps
module tb_fb_pixel_writer;
  localparam int H_RES  = 320;
  localparam int V_RES  = 240;
  localparam int ADDR_W = 17;
`ifdef PIXEL_CLIP_EN
  localparam bit CLIP = 1'b1;
`else
  localparam bit CLIP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic              draw_done = 1'b0;
  logic              mem_ready = 1'b0;
  logic [8:0]        X_in = '0;
  logic [7:0]        Y_in = '0;
  logic [6:0]        color_in = '0;
  logic              done, draw_start, mem_we, overflow;
  logic [ADDR_W-1:0] mem_addr;
  logic [6:0]        mem_data;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fb_pixel_writer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .done       (done),
    .draw_start (draw_start),
    .draw_done  (draw_done),
    .X_in       (X_in),
    .Y_in       (Y_in),
    .color_in   (color_in),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_we     (mem_we),
    .mem_ready  (mem_ready),
    .overflow   (overflow)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- monitor: records accepted writes, pulses, stall stability
  logic [23:0] wr_q[$];
  int          cyc = 0;
  int          done_cnt = 0;
  int          ds_cnt = 0;
  int          last_wr_cyc = -1;
  int          done_cyc = -1;
  bit          stall_prev = 1'b0;
  logic [23:0] stall_dat = '0;

  always @(negedge clk) begin
    cyc++;
    if (!reset_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall_hold_we", 32'(mem_we), 1);
        chk("stall_hold_dat", 32'({mem_addr, mem_data}), 32'(stall_dat));
      end
      if (mem_we && mem_ready) begin
        wr_q.push_back({mem_addr, mem_data});
        last_wr_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (draw_start) ds_cnt++;
      stall_prev = mem_we && !mem_ready;
      stall_dat  = {mem_addr, mem_data};
    end
  end

  // ---------------- reference model: pixel list -> expected write list
  int          px_x[$];
  int          px_y[$];
  int          px_c[$];
  logic [23:0] exp_q[$];

  task automatic add_px(input int x, input int y, input int c);
    px_x.push_back(x);
    px_y.push_back(y);
    px_c.push_back(c);
  endtask

  function automatic bit model_keep(input int x, input int y, input int c);
    if (c == 'h7F) return 1'b0;
    if (CLIP && (x >= H_RES || y >= V_RES)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [23:0] model_entry(input int x, input int y, input int c);
    int a;
    a = (y * H_RES + x) % (1 << ADDR_W);
    return {a[ADDR_W-1:0], c[6:0]};
  endfunction

  // Kept pixels in drawer order; kept positions [skip_lo, skip_hi) are the ones lost to a full FIFO.
  task automatic build_expected(input int skip_lo, input int skip_hi);
    int k;
    k = 0;
    exp_q.delete();
    for (int i = 0; i < px_x.size(); i++) begin
      if (model_keep(px_x[i], px_y[i], px_c[i])) begin
        if (k < skip_lo || k >= skip_hi) exp_q.push_back(model_entry(px_x[i], px_y[i], px_c[i]));
        k++;
      end
    end
  endtask

  // ---------------- memory-side ready patterns
  int ready_mode = 0;   // 0 always, 1 toggle, 2 random 7/8, 3 low until pixel index stall_k
  int stall_k = 0;

  task automatic drive_ready(input int k);
    case (ready_mode)
      0: mem_ready = 1'b1;
      1: mem_ready = ~mem_ready;
      2: mem_ready = ($urandom_range(7, 0) != 0);
      default: mem_ready = (k >= stall_k);
    endcase
  endtask

  task automatic tick(input int k);
    @(posedge clk);
    #1;
    drive_ready(k);
  endtask

  // ---------------- pass driver
  task automatic launch(input string name);
    bit seen;
    seen = 1'b0;
    wr_q.delete();
    done_cnt = 0; ds_cnt = 0; last_wr_cyc = -1; done_cyc = -1;
    tick(0);
    start = 1'b1;
    tick(0);
    start = 1'b0;
    for (int t = 0; t < 8 && !seen; t++) begin
      if (draw_start) seen = 1'b1;
      else tick(0);
    end
    chk({name, "_draw_start_seen"}, 32'(seen), 1);
    chk({name, "_ovf_clear"}, 32'(overflow), 0);
    tick(0);
  endtask

  task automatic feed(input bit busy);
    for (int i = 0; i < px_x.size(); i++) begin
      X_in     = 9'(px_x[i]);
      Y_in     = 8'(px_y[i]);
      color_in = 7'(px_c[i]);
      start    = busy && (i == 2);
      drive_ready(i);
      @(posedge clk);
      #1;
    end
    start = 1'b0;
  endtask

  task automatic run_pass(input string name, input bit busy, input bit exp_ovf,
                          input int skip_lo, input int skip_hi);
    int n;
    n = px_x.size();
    build_expected(skip_lo, skip_hi);
    launch(name);
    feed(busy);
    // draw_done cycle carries junk that must be ignored
    draw_done = 1'b1; X_in = 9'd5; Y_in = 8'd5; color_in = 7'h33;
    tick(n);
    draw_done = 1'b0; start = busy;
    tick(n);
    start = 1'b0;
    for (int t = 0; t < 1000 && done_cnt == 0; t++) tick(1 << 20);
    repeat (4) tick(1 << 20);
    chk({name, "_draw_start_cnt"}, 32'(ds_cnt), 1);
    chk({name, "_done_cnt"}, 32'(done_cnt), 1);
    chk({name, "_wr_cnt"}, 32'(wr_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
      chk({name, "_wr"}, 32'(wr_q[i]), 32'(exp_q[i]));
    if (last_wr_cyc >= 0) chk({name, "_done_after_wr"}, 32'(done_cyc > last_wr_cyc), 1);
    chk({name, "_ovf"}, 32'(overflow), 32'(exp_ovf));
    px_x.delete(); px_y.delete(); px_c.delete();
  endtask

  task automatic chk_zero_outputs(input string name);
    chk({name, "_done"}, 32'(done), 0);
    chk({name, "_draw_start"}, 32'(draw_start), 0);
    chk({name, "_mem_we"}, 32'(mem_we), 0);
    chk({name, "_overflow"}, 32'(overflow), 0);
    chk({name, "_mem_addr"}, 32'(mem_addr), 0);
    chk({name, "_mem_data"}, 32'(mem_data), 0);
  endtask

  initial begin
    #100000000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_zero_outputs("reset");
    reset_n = 1'b1;

    // single pixel
    ready_mode = 0;
    add_px(40, 10, 'h70);
    run_pass("single", 1'b0, 1'b0, 0, 0);

    // transparent alternation, with ignored start pulses in CAPTURE and DRAIN
    for (int i = 0; i < 8; i++) add_px(40 + i, 11, (i % 2 == 0) ? 'h54 : 'h7F);
    run_pass("transp", 1'b1, 1'b0, 0, 0);

    // stall: ready low for the first 30 pixels of a 102-pixel row
    ready_mode = 3; stall_k = 30;
    for (int i = 0; i < 102; i++) add_px(i, 50, $urandom_range(126, 0));
    run_pass("stall", 1'b0, 1'b1, 16, 30);

    // pointer wraps with ready toggling each cycle
    ready_mode = 1;
    for (int i = 0; i < 130; i++)
      add_px($urandom_range(H_RES - 1, 0), $urandom_range(V_RES - 1, 0),
             (i % 2 == 1) ? 'h7F : $urandom_range(126, 0));
    run_pass("wrap", 1'b0, 1'b0, 0, 0);

    // random coordinates (including out of range) and random ready
    ready_mode = 2;
    for (int i = 0; i < 80; i++)
      add_px($urandom_range(511, 0), $urandom_range(255, 0),
             ($urandom_range(1, 0) == 1) ? 'h7F : $urandom_range(126, 0));
    run_pass("random", 1'b0, 1'b0, 0, 0);

    // edge-of-frame and just-outside pixels
    ready_mode = 0;
    add_px(319, 239, 'h22);
    add_px(320, 0, 'h23);
    add_px(0, 240, 'h24);
    run_pass("clip", 1'b0, 1'b0, 0, 0);

    // reset mid-CAPTURE with five entries queued
    ready_mode = 3; stall_k = 1000;
    for (int i = 0; i < 5; i++) add_px(i, 3, 'h10 + i);
    launch("rstpass");
    feed(1'b0);
    chk("rst_pre_we", 32'(mem_we), 1);
    reset_n = 1'b0;
    #1;
    chk_zero_outputs("rst_mid");
    X_in = '0; Y_in = '0; color_in = '0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    ready_mode = 0;
    wr_q.delete(); done_cnt = 0;
    repeat (10) tick(0);
    chk("rst_no_wr", 32'(wr_q.size()), 0);
    chk("rst_no_done", 32'(done_cnt), 0);
    px_x.delete(); px_y.delete(); px_c.delete();

    // recovery after reset
    add_px(7, 2, 'h41);
    run_pass("recover", 1'b0, 1'b0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
